// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus gate arbiter.
package bus_pkg;

    // Arbitration policy selector (maps onto the MODE parameter).
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Default source index map on the datapath bus.
    localparam int SRC_PC  = 0;
    localparam int SRC_MDR = 1;
    localparam int SRC_MAR = 2;
    localparam int SRC_ALU = 3;

    // Default bus data width.
    localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/bus_gate_arbiter_rot_prio_enc.sv
// Rotating priority encoder: first set request at or after start_ptr_i
// (wrapping modulo N) wins. start_ptr_i == 0 gives plain lowest-index priority.
module rot_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    // Walk N positions starting at the pointer; the first hit wins.
    always_comb begin
        int p;
        p     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int off = 0; off < N; off++) begin
            // start_ptr_i is always < N, so one subtraction wraps it.
            p = int'(start_ptr_i) + off;
            if (p >= N) p = p - N;
            if (!vld_o && req_i[p]) begin
                vld_o    = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = IW'(p);
            end
        end
    end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Shared CPU bus arbiter: picks one gated source (fixed priority or
// round-robin), keeps the last driven value on idle cycles, and tracks
// multi-gate contention for debug.
module bus_gate_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_SRC = 4,
    parameter int MODE    = 0,
    parameter int REG_OUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         gate,
    input  logic [NUM_SRC*WIDTH-1:0]   data_in,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           bus_q,
    output logic                       bus_valid,
    output logic [NUM_SRC-1:0]         grant,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       contention,
    output logic                       contention_sticky,
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int IW = $clog2(NUM_SRC);

    logic [WIDTH-1:0]   src [NUM_SRC];
    logic [NUM_SRC-1:0] win_oh;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic [IW-1:0]      start_ptr;
    logic               cont_c;
    logic [WIDTH-1:0]   bus_c;

    logic [WIDTH-1:0]   keeper_q, keeper_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Unpack the flat source bus into one word per source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Fixed priority is just the rotating search anchored at index 0.
    assign start_ptr = (MODE == int'(ARB_RR)) ? rr_ptr_q : '0;

    rot_prio_enc #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_enc (
        .req_i       (gate),
        .start_ptr_i (start_ptr),
        .gnt_o       (win_oh),
        .idx_o       (win_idx),
        .vld_o       (win_vld)
    );

    assign cont_c = $countones(gate) > 1;
    assign bus_c  = win_vld ? src[win_idx] : keeper_q;

    // Next state for keeper, round-robin pointer and contention tracking.
    always_comb begin
        keeper_d = keeper_q;
        rr_ptr_d = rr_ptr_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (win_vld) begin
            keeper_d = src[win_idx];
            rr_ptr_d = (win_idx == IW'(NUM_SRC - 1)) ? '0 : win_idx + IW'(1);
        end
        // A clear in a contention cycle still counts that cycle's event.
        if (clr_err) begin
            sticky_d = cont_c;
            cnt_d    = cont_c ? CNT_W'(1) : '0;
        end else if (cont_c) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops keeper and round-robin history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            keeper_q <= '0;
            rr_ptr_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            keeper_q <= keeper_d;
            rr_ptr_q <= rr_ptr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign contention_sticky = sticky_q;
    assign contention_cnt    = cnt_q;

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0]   bus_r;
        logic               vld_r;
        logic [NUM_SRC-1:0] gnt_r;
        logic [IW-1:0]      idx_r;
        logic               cont_r;

        // One-cycle output stage; all bus-side outputs move together.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                bus_r  <= '0;
                vld_r  <= 1'b0;
                gnt_r  <= '0;
                idx_r  <= '0;
                cont_r <= 1'b0;
            end else begin
                bus_r  <= bus_c;
                vld_r  <= win_vld;
                gnt_r  <= win_oh;
                idx_r  <= win_idx;
                cont_r <= cont_c;
            end
        end

        assign bus_q      = bus_r;
        assign bus_valid  = vld_r;
        assign grant      = gnt_r;
        assign grant_idx  = idx_r;
        assign contention = cont_r;
    end else begin : g_comb_out
        assign bus_q      = bus_c;
        assign bus_valid  = win_vld;
        assign grant      = win_oh;
        assign grant_idx  = win_idx;
        assign contention = cont_c;
    end

endmodule
